// File: rtl/cga_mic_pkg.sv
// Shared types and constants for the /CGA/MIC loop-counter sequencer.
// Holds the FSM state enum and the counter polarity helper.
package cga_mic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [1:0] TERM_DEF  = 2'd3;
  localparam logic [1:0] CSWAN_INV = 2'b11;

  // CSWAN0/CSWAN1 are active-low; this yields the true count
  function automatic logic [1:0] cswan_cnt(
    input logic [1:0] cswan
  );
    return cswan ^ CSWAN_INV;
  endfunction

endpackage

// File: rtl/cga_mic_loopctl_if.sv
// Microsequencer / loop counter bundle for cga_mic_loopctl.
// master = microsequencer+counter side, slave = the sequencer.
interface cga_mic_loopctl_if;

  logic       REQ;
  logic [1:0] REQ_CNT;
  logic       STEP;
  logic       ABORT;
  logic [1:0] CSWAN;
  logic [1:0] CD;
  logic       LWCAN;
  logic       EC;
  logic       BUSY;
  logic       DONE;
  logic       ABORTED;

  modport master (
    output REQ, REQ_CNT, STEP, ABORT, CSWAN,
    input  CD, LWCAN, EC, BUSY, DONE, ABORTED
  );

  modport slave (
    input  REQ, REQ_CNT, STEP, ABORT, CSWAN,
    output CD, LWCAN, EC, BUSY, DONE, ABORTED
  );

endinterface

// File: rtl/cga_mic_loopctl_wdog.sv
// RUN-state watchdog for cga_mic_loopctl.
// Counts step-less RUN cycles; expire is asserted on the limit cycle.
module cga_mic_loopctl_wdog #(
  parameter int TMO_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic step,
  output logic expire
);

  localparam int W = $clog2(TMO_CYCLES + 1);

  logic [W-1:0] cnt_q;

  assign expire = run & ~step &
    (cnt_q == W'(TMO_CYCLES - 1));

  // held at zero outside RUN, so entry to RUN starts from 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!run || step) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/cga_mic_loopctl.sv
// Loop sequencer driving the /CGA/MIC 2-bit loop counter (LWCAN/EC).
// Optional watchdog + TMO port: define CGA_MIC_LOOPCTL_TIMEOUT_EN.
module cga_mic_loopctl
  import cga_mic_pkg::*;
#(
  parameter logic [1:0] TERM = TERM_DEF,
  parameter int TMO_CYCLES = 16
) (
  input  logic MCLK,
  input  logic MRN,
  cga_mic_loopctl_if.slave bus
`ifdef CGA_MIC_LOOPCTL_TIMEOUT_EN
  ,
  output logic TMO
`endif
);

  state_t     state_q, state_d;
  logic       at_term, kill, fin, ec;
  logic [1:0] cd_q, cd_d;
  logic       lwcan_q, lwcan_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       abrt_q, abrt_d;

  assign at_term = cswan_cnt(bus.CSWAN) == TERM;

`ifdef CGA_MIC_LOOPCTL_TIMEOUT_EN
  logic expire;
  logic tmo_q;

  cga_mic_loopctl_wdog #(
    .TMO_CYCLES(TMO_CYCLES)
  ) u_wdog (
    .clk    (MCLK),
    .rst_n  (MRN),
    .run    (state_q == ST_RUN),
    .step   (bus.STEP),
    .expire (expire)
  );

  assign kill = bus.ABORT | expire;

  always_ff @(posedge MCLK or negedge MRN) begin
    if (!MRN) begin
      tmo_q <= 1'b0;
    end else if (state_q == ST_IDLE && bus.REQ) begin
      tmo_q <= 1'b0;
    end else if (expire) begin
      tmo_q <= 1'b1;
    end
  end

  assign TMO = tmo_q;
`else
  assign kill = bus.ABORT;
`endif

  assign fin = (state_q == ST_RUN) & bus.STEP
             & at_term & ~kill;

  always_ff @(posedge MCLK or negedge MRN) begin
    if (!MRN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.REQ) state_d = ST_LOAD;
      ST_LOAD: state_d = kill ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (kill)     state_d = ST_IDLE;
        else if (fin) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cd_d    = cd_q;
    lwcan_d = 1'b1;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abrt_d  = 1'b0;
    ec      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.REQ) begin
          cd_d    = bus.REQ_CNT;
          lwcan_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (kill) begin
          busy_d = 1'b0;
          abrt_d = 1'b1;
        end
      end
      ST_RUN: begin
        ec = bus.STEP & ~kill & ~at_term;
        if (kill) begin
          busy_d = 1'b0;
          abrt_d = 1'b1;
        end else if (fin) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge MCLK or negedge MRN) begin
    if (!MRN) begin
      cd_q    <= 2'b00;
      lwcan_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
    end else begin
      cd_q    <= cd_d;
      lwcan_q <= lwcan_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
    end
  end

  assign bus.CD      = cd_q;
  assign bus.LWCAN   = lwcan_q;
  assign bus.EC      = ec;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.ABORTED = abrt_q;

endmodule

// File: tb/tb_cga_mic_loopctl.sv
// Scoreboard bench for cga_mic_loopctl with an attached 2-bit counter.
// Loop outcomes are predicted per request and checked on DONE/ABORTED.
module tb_cga_mic_loopctl;

  localparam int TERM = 3;

  typedef struct {
    bit         ab;
    logic [1:0] cd;
    int         ec;
    logic [1:0] fin;
  } exp_t;

  logic MCLK;
  logic MRN;
  logic tmo;
  logic [1:0] cnt;

  exp_t q[$];
  int   gaps[$];
  int   total = 0;
  int   bad = 0;

  cga_mic_loopctl_if bus();

  cga_mic_loopctl #(.TMO_CYCLES(4)) dut (
    .MCLK (MCLK),
    .MRN  (MRN),
    .bus  (bus)
`ifdef CGA_MIC_LOOPCTL_TIMEOUT_EN
    ,
    .TMO  (tmo)
`endif
  );

`ifndef CGA_MIC_LOOPCTL_TIMEOUT_EN
  assign tmo = 1'b0;
`endif

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  always @(posedge MCLK or negedge MRN) begin
    if (!MRN)           cnt <= 2'd0;
    else if (!bus.LWCAN) cnt <= bus.CD;
    else if (bus.EC)    cnt <= cnt + 2'd1;
  end
  assign bus.CSWAN = ~cnt;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endfunction

  logic [1:0] cd_c = 2'd0;
  int         ec_c = 0;
  int         cyc = 0;
  int         last_done = -1;

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge MCLK);
      cyc++;
      if (!MRN) begin
        ec_c = 0;
        last_done = -1;
        continue;
      end
      if (!bus.LWCAN) begin
        cd_c = bus.CD;
        ec_c = 0;
        chk("busy_in_load", bus.BUSY, 1);
        if (last_done >= 0)
          gaps.push_back(cyc - last_done);
        last_done = -1;
      end
      if (bus.EC) ec_c++;
      if (bus.DONE || bus.ABORTED) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = q.pop_front();
          chk("aborted", bus.ABORTED, e.ab);
          chk("done", bus.DONE, !e.ab);
          chk("cd", cd_c, e.cd);
          chk("ec_count", ec_c, e.ec);
          chk("final_count", cnt, e.fin);
          chk("busy_low", bus.BUSY, 0);
        end
        if (bus.DONE) last_done = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  function automatic int steps_for(logic [1:0] s);
    return (TERM - int'(s) + 4) % 4 + 1;
  endfunction

  task automatic do_loop(
    input logic [1:0] s,
    input int ab_m,
    input bit ab_load,
    input bit ab_step,
    input bit hold,
    input int gmin,
    input int gmax
  );
    int n, m;
    exp_t e;
    n = steps_for(s);
    e.cd = s;
    if (ab_load) begin
      e.ab = 1; e.ec = 0; e.fin = s;
    end else if (ab_m >= 0) begin
      e.ab = 1; e.ec = ab_m;
      e.fin = 2'(int'(s) + ab_m);
    end else begin
      e.ab = 0; e.ec = n - 1; e.fin = 2'(TERM);
    end
    q.push_back(e);
    bus.REQ = 1'b1;
    bus.REQ_CNT = s;
    tick();
    if (!hold) bus.REQ = 1'b0;
    bus.REQ_CNT = 2'($urandom);
    bus.STEP = 1'($urandom);
    bus.ABORT = ab_load;
    tick();
    bus.STEP = 1'b0;
    bus.ABORT = 1'b0;
    if (ab_load) return;
    m = (ab_m >= 0) ? ab_m : n;
    for (int i = 0; i < m; i++) begin
      idle($urandom_range(gmax, gmin));
      bus.STEP = 1'b1;
      tick();
      bus.STEP = 1'b0;
    end
    if (ab_m >= 0) begin
      idle($urandom_range(gmax, gmin));
      bus.ABORT = 1'b1;
      bus.STEP = ab_step;
      tick();
      bus.ABORT = 1'b0;
      bus.STEP = 1'b0;
    end else begin
      tick();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_lwcan"}, bus.LWCAN, 1);
    chk({tag, "_ec"}, bus.EC, 0);
    chk({tag, "_busy"}, bus.BUSY, 0);
    chk({tag, "_cd"}, bus.CD, 0);
    chk({tag, "_done"}, bus.DONE, 0);
    chk({tag, "_aborted"}, bus.ABORTED, 0);
  endtask

  initial begin : drv
    logic [1:0] s;
    int md;
    MRN = 1'b0;
    bus.REQ = 1'b0;
    bus.REQ_CNT = 2'd0;
    bus.STEP = 1'b0;
    bus.ABORT = 1'b0;
    idle(3);
    chk_reset_vals("rst");
    MRN = 1'b1;
    tick();

    do_loop(2'd1, -1, 0, 0, 0, 1, 1);
    do_loop(2'd3, -1, 0, 0, 0, 0, 1);
    do_loop(2'd0, 1, 0, 1, 0, 1, 1);

    bus.REQ = 1'b1;
    bus.REQ_CNT = 2'd0;
    tick();
    bus.REQ = 1'b0;
    tick();
    bus.STEP = 1'b1;
    tick();
    bus.STEP = 1'b0;
    tick();
    #2 MRN = 1'b0;
    #1 chk_reset_vals("midrst");
    chk("midrst_cnt", cnt, 0);
    tick();
    MRN = 1'b1;
    idle(3);

    gaps.delete();
    do_loop(2'd2, -1, 0, 0, 1, 0, 1);
    do_loop(2'd0, -1, 0, 0, 1, 0, 1);
    do_loop(2'd3, -1, 0, 0, 0, 0, 1);
    chk("b2b_loads", gaps.size(), 2);
    if (gaps.size() == 2) begin
      chk("b2b_gap0", gaps[0], 2);
      chk("b2b_gap1", gaps[1], 2);
    end

    repeat (40) begin
      s = 2'($urandom);
      md = int'($urandom_range(0, 3));
      if (md == 0)
        do_loop(s, -1, 1, 0, 0, 0, 2);
      else if (md == 1)
        do_loop(s, int'($urandom_range(0,
                steps_for(s) - 1)),
                0, 1'($urandom), 0, 0, 2);
      else
        do_loop(s, -1, 0, 0, 0, 0, 2);
      idle($urandom_range(0, 2));
    end

`ifdef CGA_MIC_LOOPCTL_TIMEOUT_EN
    begin
      exp_t e;
      e.ab = 1; e.cd = 2'd0; e.ec = 0; e.fin = 2'd0;
      q.push_back(e);
      bus.REQ = 1'b1;
      bus.REQ_CNT = 2'd0;
      tick();
      bus.REQ = 1'b0;
      idle(5);
      chk("tmo_set", tmo, 1);
      do_loop(2'd3, -1, 0, 0, 0, 0, 1);
      chk("tmo_clr", tmo, 0);
    end
`endif

    idle(4);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
